// File: rtl/cra_seq_ctrl.sv
// Multi-cycle add/subtract controller that drives one external 4-bit CRA slice,
// one nibble per clock, LSB first, with the inter-nibble carry held in a register.
module cra_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic [3:0]       cra_x,
  output logic [3:0]       cra_y,
  output logic             cra_cin,
  input  logic [3:0]       cra_s,
  input  logic             cra_cout
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned SELW   = (WIDTH > 4) ? $clog2(WIDTH) : 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [SELW-1:0]  nib_base;
  logic [WIDTH-1:0] result_c;
  logic             last_nib;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign nib_base = SELW'({idx_q, 2'b00});
  assign last_nib = (idx_q == IDXW'(NSLICE - 1));

  // Next-state, nibble sequencing and CRA drive
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    cra_x    = 4'd0;
    cra_y    = 4'd0;
    cra_cin  = 1'b0;
    result_c = acc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        cra_x   = opa_q[nib_base +: 4];
        cra_y   = opb_q[nib_base +: 4];
        cra_cin = carry_q;
        result_c[nib_base +: 4] = cra_s;
        acc_d   = result_c;
        carry_d = cra_cout;
        idx_d   = idx_q + IDXW'(1);
        if (last_nib) begin
          state_d = S_DONE;
          sum_d   = result_c;
          c_out_d = cra_cout;
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (result_c[WIDTH-1] != opa_q[WIDTH-1]);
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_cra_seq_ctrl.sv
// Bench for cra_seq_ctrl: behavioural CRA slice, directed plan cases, then randomized
// operations with back-to-back starts and ignored starts checked against arithmetic.
module tb_cra_seq_ctrl;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic [3:0]   cra_x;
  logic [3:0]   cra_y;
  logic         cra_cin;
  logic [3:0]   cra_s;
  logic         cra_cout;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] e_a;
  logic [W-1:0] e_b;
  logic         e_sub;
  logic [W-1:0] e_sum;

  cra_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf),
    .cra_x    (cra_x),
    .cra_y    (cra_y),
    .cra_cin  (cra_cin),
    .cra_s    (cra_s),
    .cra_cout (cra_cout)
  );

  // External 4-bit ripple-carry adder slice
  assign {cra_cout, cra_s} = {1'b0, cra_x} + {1'b0, cra_y} + {4'd0, cra_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge: presents a request for one cycle, then scrambles the inputs
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    start = 1'b1;
    a     = ta;
    b     = tb;
    sub   = ts;
    e_a   = ta;
    e_b   = tb;
    e_sub = ts;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
  endtask

  // Walks the four RUN cycles and checks the DONE cycle; glitch selects a RUN cycle
  // in which a stray start with junk operands is presented (>=4 means none)
  task automatic run_check(input int glitch);
    logic [W-1:0] mask;
    logic [W:0]   lsum;
    logic         exp_cin;
    logic         exp_cout;
    logic         exp_ovf;
    int           sa;
    int           sb;
    int           sr;
    for (int i = 0; i < 4; i++) begin
      mask = W'((32'd1 << (4 * i)) - 32'd1);
      if (e_sub) begin
        exp_cin = ((e_a & mask) >= (e_b & mask));
      end else begin
        lsum    = (W+1)'(e_a & mask) + (W+1)'(e_b & mask);
        exp_cin = lsum[4 * i];
      end
      chk($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
      chk($sformatf("done_run%0d", i), 32'(done), 32'd0);
      chk($sformatf("cra_cin_run%0d", i), 32'(cra_cin), 32'(exp_cin));
      chk($sformatf("cra_x_run%0d", i), 32'(cra_x), 32'((e_a >> (4 * i)) & W'(15)));
      if (i == glitch) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;

    sa = int'($signed(e_a));
    sb = int'($signed(e_b));
    if (e_sub) begin
      e_sum    = e_a - e_b;
      exp_cout = (e_a >= e_b);
      sr       = sa - sb;
    end else begin
      lsum     = (W+1)'(e_a) + (W+1)'(e_b);
      e_sum    = lsum[W-1:0];
      exp_cout = lsum[W];
      sr       = sa + sb;
    end
    exp_ovf = (sr > 32767) || (sr < -32768);

    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk($sformatf("sum_%0h_%0h_%0d", e_a, e_b, e_sub), 32'(sum), 32'(e_sum));
    chk("c_out", 32'(c_out), 32'(exp_cout));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("cra_cin_idle", 32'(cra_cin), 32'd0);
  endtask

  // Advance from DONE into IDLE and confirm the result is held
  task automatic idle_check();
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum), 32'(e_sum));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    e_sum = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_cra_x", 32'(cra_x), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(16'h0001, 16'h0003, 1'b0); run_check(4); idle_check();
    launch(16'hFFFF, 16'h0001, 1'b0); run_check(4); idle_check();
    launch(16'h0005, 16'h0003, 1'b1); run_check(4);
    launch(16'h0003, 16'h0005, 1'b1); run_check(4); idle_check();
    launch(16'h7FFF, 16'h0001, 1'b0); run_check(4); idle_check();
    launch(16'h8000, 16'h0001, 1'b1); run_check(4); idle_check();

    // Stray start in the 2nd RUN cycle must not disturb the operation
    launch(16'h1234, 16'h0F0F, 1'b0); run_check(1); idle_check();

    // Reset in the 3rd RUN cycle aborts and clears everything
    launch(16'hABCD, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_c_out", 32'(c_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_cra_cin", 32'(cra_cin), 32'd0);
    chk("abort_cra_y", 32'(cra_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    launch(16'h00FF, 16'h0001, 1'b0); run_check(4); idle_check();

    // Randomized operations, randomly chained back-to-back from DONE
    for (int n = 0; n < 40; n++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom));
      run_check(int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
